// File: rtl/calc_pkg.sv
// Shared calculator widths, command/response encodings and the response-entry
// types carried through the result pipes and the response FIFO.
package calc_pkg;

  localparam int unsigned CALC_CMD_WIDTH   = 4;
  localparam int unsigned CALC_DATA_WIDTH  = 32;
  localparam int unsigned CALC_TAG_WIDTH   = 2;
  localparam int unsigned CALC_RESP_WIDTH  = 2;
  localparam int unsigned CALC_SHAMT_WIDTH = 5;

  localparam logic [CALC_CMD_WIDTH-1:0] CALC_CMD_NOP = CALC_CMD_WIDTH'(0);
  localparam logic [CALC_CMD_WIDTH-1:0] CALC_CMD_ADD = CALC_CMD_WIDTH'(1);
  localparam logic [CALC_CMD_WIDTH-1:0] CALC_CMD_SUB = CALC_CMD_WIDTH'(2);
  localparam logic [CALC_CMD_WIDTH-1:0] CALC_CMD_SHL = CALC_CMD_WIDTH'(5);
  localparam logic [CALC_CMD_WIDTH-1:0] CALC_CMD_SHR = CALC_CMD_WIDTH'(6);

  localparam logic [CALC_RESP_WIDTH-1:0] CALC_RESP_NONE = 2'b00;
  localparam logic [CALC_RESP_WIDTH-1:0] CALC_RESP_OK   = 2'b01;
  localparam logic [CALC_RESP_WIDTH-1:0] CALC_RESP_ERR  = 2'b10;

  typedef struct packed {
    logic [CALC_RESP_WIDTH-1:0] resp;
    logic [CALC_DATA_WIDTH-1:0] data;
    logic [CALC_TAG_WIDTH-1:0]  tag;
  } calc_resp_t;

  typedef struct packed {
    logic       valid;
    calc_resp_t ent;
  } calc_stage_t;

  // Shifts take the long pipe; everything else (including invalid) the short one.
  function automatic logic calc_is_shift(input logic [CALC_CMD_WIDTH-1:0] cmd);
    return (cmd == CALC_CMD_SHL) || (cmd == CALC_CMD_SHR);
  endfunction

endpackage

// File: rtl/calc_resp_fifo.sv
// Response FIFO with two write ports (port 0 is the older entry and lands first)
// and one read port; the head is presented as zero while empty.
module calc_resp_fifo
  import calc_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_wr0,
  input  calc_resp_t i_wr0_data,
  input  logic       i_wr1,
  input  calc_resp_t i_wr1_data,
  input  logic       i_rd,
  output calc_resp_t o_rd_data
);

  localparam int unsigned PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW  = $clog2(DEPTH + 1);
  localparam int unsigned CW1 = CW + 1;

  calc_resp_t     r_mem [DEPTH];
  logic [PW-1:0]  r_wptr;
  logic [PW-1:0]  r_rptr;
  logic [CW-1:0]  r_count;
  logic [PW-1:0]  w_wptr_p1;
  logic [PW-1:0]  w_wptr_p2;
  logic [1:0]     w_nwr;
  logic           w_pop;
  logic [CW1-1:0] w_count_nxt;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign w_wptr_p1   = ptr_inc(r_wptr);
  assign w_wptr_p2   = ptr_inc(w_wptr_p1);
  assign w_nwr       = {1'b0, i_wr0} + {1'b0, i_wr1};
  assign w_pop       = i_rd && (r_count != '0);
  assign w_count_nxt = CW1'(r_count) + CW1'(w_nwr) - CW1'(w_pop);
  assign o_rd_data   = (r_count != '0) ? r_mem[r_rptr] : '0;

  // A lone port-1 write takes the current slot so entries stay contiguous.
  always_ff @(posedge clk) begin
    if (i_wr0) r_mem[r_wptr] <= i_wr0_data;
    if (i_wr1) r_mem[i_wr0 ? w_wptr_p1 : r_wptr] <= i_wr1_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      case ({i_wr0, i_wr1})
        2'b11:        r_wptr <= w_wptr_p2;
        2'b10, 2'b01: r_wptr <= w_wptr_p1;
        default:      r_wptr <= r_wptr;
      endcase
      if (w_pop) r_rptr <= ptr_inc(r_rptr);
      r_count <= w_count_nxt[CW-1:0];
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    w_count_nxt <= CW1'(DEPTH));

endmodule

// File: rtl/calc_port_responder.sv
// Two-cycle request port (command + operand 1, then operand 2) feeding an ALU
// pipe and a longer shift pipe that merge, shift-first, into a response FIFO.
module calc_port_responder
  import calc_pkg::*;
#(
  parameter int unsigned ALU_LAT    = 2,
  parameter int unsigned SHF_LAT    = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                       PClk,
  input  logic                       Rst,
  input  logic [CALC_CMD_WIDTH-1:0]  req_cmd_in,
  input  logic [CALC_DATA_WIDTH-1:0] req_data_in,
  input  logic [CALC_TAG_WIDTH-1:0]  req_tag_in,
  output logic [CALC_RESP_WIDTH-1:0] out_resp,
  output logic [CALC_DATA_WIDTH-1:0] out_data,
  output logic [CALC_TAG_WIDTH-1:0]  out_tag
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_OP2  = 1'b1;

  logic [0:0]                  r_state;
  logic [0:0]                  w_state_nxt;
  logic                        w_capture;
  logic                        w_issue;
  logic [CALC_CMD_WIDTH-1:0]   r_cmd;
  logic [CALC_TAG_WIDTH-1:0]   r_tag;
  logic [CALC_DATA_WIDTH-1:0]  r_op1;
  logic [CALC_DATA_WIDTH:0]    w_sum;
  logic [CALC_SHAMT_WIDTH-1:0] w_shamt;
  logic                        w_is_shift;
  calc_resp_t                  w_result;
  calc_stage_t                 w_alu_in;
  calc_stage_t                 w_shf_in;
  calc_stage_t                 r_alu_pipe [ALU_LAT];
  calc_stage_t                 r_shf_pipe [SHF_LAT];
  calc_resp_t                  w_fifo_head;

  always_ff @(posedge PClk) begin
    if (Rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // OP2 always returns to IDLE, so the command input is never looked at there.
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_issue     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req_cmd_in != CALC_CMD_NOP) begin
          w_state_nxt = ST_OP2;
          w_capture   = 1'b1;
        end
      end
      ST_OP2: begin
        w_state_nxt = ST_IDLE;
        w_issue     = 1'b1;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge PClk) begin
    if (Rst) begin
      r_cmd <= '0;
      r_tag <= '0;
      r_op1 <= '0;
    end else if (w_capture) begin
      r_cmd <= req_cmd_in;
      r_tag <= req_tag_in;
      r_op1 <= req_data_in;
    end
  end

  assign w_sum      = {1'b0, r_op1} + {1'b0, req_data_in};
  assign w_shamt    = req_data_in[CALC_SHAMT_WIDTH-1:0];
  assign w_is_shift = calc_is_shift(r_cmd);

  // Error responses always carry zero data.
  always_comb begin
    w_result = '{resp: CALC_RESP_ERR, data: '0, tag: r_tag};
    case (r_cmd)
      CALC_CMD_ADD: begin
        if (!w_sum[CALC_DATA_WIDTH]) begin
          w_result.resp = CALC_RESP_OK;
          w_result.data = w_sum[CALC_DATA_WIDTH-1:0];
        end
      end
      CALC_CMD_SUB: begin
        if (req_data_in <= r_op1) begin
          w_result.resp = CALC_RESP_OK;
          w_result.data = r_op1 - req_data_in;
        end
      end
      CALC_CMD_SHL: begin
        w_result.resp = CALC_RESP_OK;
        w_result.data = r_op1 << w_shamt;
      end
      CALC_CMD_SHR: begin
        w_result.resp = CALC_RESP_OK;
        w_result.data = r_op1 >> w_shamt;
      end
      default: ;
    endcase
  end

  assign w_alu_in = '{valid: w_issue && !w_is_shift, ent: w_result};
  assign w_shf_in = '{valid: w_issue &&  w_is_shift, ent: w_result};

  always_ff @(posedge PClk) begin
    if (Rst) begin
      for (int unsigned i = 0; i < ALU_LAT; i++) r_alu_pipe[i] <= '0;
      for (int unsigned i = 0; i < SHF_LAT; i++) r_shf_pipe[i] <= '0;
    end else begin
      r_alu_pipe[0] <= w_alu_in;
      r_shf_pipe[0] <= w_shf_in;
      for (int unsigned i = 1; i < ALU_LAT; i++) r_alu_pipe[i] <= r_alu_pipe[i-1];
      for (int unsigned i = 1; i < SHF_LAT; i++) r_shf_pipe[i] <= r_shf_pipe[i-1];
    end
  end

  // The shift result was issued earlier, so it takes the older write port.
  calc_resp_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (PClk),
    .rst        (Rst),
    .i_wr0      (r_shf_pipe[SHF_LAT-1].valid),
    .i_wr0_data (r_shf_pipe[SHF_LAT-1].ent),
    .i_wr1      (r_alu_pipe[ALU_LAT-1].valid),
    .i_wr1_data (r_alu_pipe[ALU_LAT-1].ent),
    .i_rd       (1'b1),
    .o_rd_data  (w_fifo_head)
  );

  assign out_resp = w_fifo_head.resp;
  assign out_data = w_fifo_head.data;
  assign out_tag  = w_fifo_head.tag;

endmodule
